// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the nibble-serial datapath: the 4-bit ALU command set,
//   its argument/return bundles, and the default nibble-index width.
//   No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  // Index width used by the nibble sequencer; a word holds 2**CNT_SIZE nibbles.
  localparam int CNT_SIZE_DEF = 3;
  localparam int NIBBLE_W     = 4;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND   = 3'd2,
    OR    = 3'd3,
    XOR   = 3'd4,
    RSHFT = 3'd5
  } AluCmd;

  typedef struct packed {
    AluCmd cmd;
    struct packed {
      logic carry_in;
    } ctrl;
  } AluCtrl;

  typedef struct packed {
    AluCtrl               ctrl;
    logic [NIBBLE_W-1:0]  d1;
    logic [NIBBLE_W-1:0]  d2;
  } AluArgs;

  typedef struct packed {
    logic [NIBBLE_W-1:0]  res;
    logic                 carry_out;
  } AluRet;

endpackage

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
//   Stateless 4-bit ALU used for one nibble step of the nibble-serial loop.
//   The caller chains carry_out of one step into carry_in of the next.
// Ports
//   args : input  AluArgs  command, carry_in, operands d1 / d2
//   ret  : output AluRet   nibble result and carry_out
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
(
  input  AluArgs args,
  output AluRet  ret
);

  logic [NIBBLE_W:0] sum;
  logic              cin;

  assign cin = args.ctrl.ctrl.carry_in;

  always_comb begin
    sum = '0;
    ret = '0;
    case (args.ctrl.cmd)
      ADD: begin
        sum = {1'b0, args.d1} + {1'b0, args.d2} + {{NIBBLE_W{1'b0}}, cin};
        {ret.carry_out, ret.res} = sum;
      end
      // Subtract as d1 + ~d2 + cin; the loop seeds cin=1 on the first nibble,
      // so carry_out=1 reads as "no borrow".
      SUB: begin
        sum = {1'b0, args.d1} + {1'b0, ~args.d2} + {{NIBBLE_W{1'b0}}, cin};
        {ret.carry_out, ret.res} = sum;
      end
      AND: ret.res = args.d1 & args.d2;
      OR:  ret.res = args.d1 | args.d2;
      XOR: ret.res = args.d1 ^ args.d2;
      // One-bit right shift across nibbles: carry_in enters at the top, the
      // bit falling off the bottom feeds the next lower nibble.
      RSHFT: begin
        ret.res       = {cin, args.d2[NIBBLE_W-1:1]};
        ret.carry_out = args.d2[0];
      end
      default: ret = '0;
    endcase
  end

endmodule

// File: rtl/nibble_counter.sv
// ---------------------------------------------------------------------------
// nibble_counter
//   Nibble-index sequencer for the nibble-serial datapath. Steps idx over the
//   nibbles of a word, upward (0 -> width) or downward (width -> 0), and
//   flags the final nibble of the sweep. Saturates at the end; never wraps.
// Ports
//   clk               : input  1         rising-edge clock
//   rst_n             : input  1         asynchronous active-low reset (idx=0)
//   perm_to_count     : input  1         1 = advance, 0 = reload start index
//   width             : input  CNT_SIZE  index of most-significant nibble used
//   reverse_direction : input  1         1 = count width->0, 0 = count 0->width
//   is_latest         : output 1         idx is the final nibble of the sweep
//   idx               : output CNT_SIZE  current nibble index (registered)
// ---------------------------------------------------------------------------
module nibble_counter
  import alu_pkg::*;
#(
  parameter int CNT_SIZE = CNT_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                perm_to_count,
  input  logic [CNT_SIZE-1:0] width,
  input  logic                reverse_direction,
  output logic                is_latest,
  output logic [CNT_SIZE-1:0] idx
);

  localparam logic [CNT_SIZE-1:0] ONE = CNT_SIZE'(1);

  logic [CNT_SIZE-1:0] start_idx;
  logic [CNT_SIZE-1:0] idx_next;

  assign start_idx = reverse_direction ? width : '0;

  // Combinational so the clock that sees is_latest=1 still processes the
  // last nibble; the loop's busy is perm_to_count & ~is_latest.
  assign is_latest = reverse_direction ? (idx == '0) : (idx == width);

  always_comb begin
    idx_next = idx;
    if (!perm_to_count) begin
      idx_next = start_idx;
    end else if (!is_latest) begin
      idx_next = reverse_direction ? (idx - ONE) : (idx + ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else begin
      idx <= idx_next;
    end
  end

endmodule

// File: tb/tb_nibble_counter.sv
// ---------------------------------------------------------------------------
// tb_nibble_counter
//   Directed bench for the nibble sequencer, the 4-bit alu, and a 32-bit
//   nibble loop built from both (idx drives the operand mux and result demux).
// ---------------------------------------------------------------------------
module tb_nibble_counter;
  import alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic       perm;
  logic [2:0] width;
  logic       rev;
  logic       is_latest;
  logic [2:0] idx;

  AluArgs alu_args;
  AluRet  alu_ret;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  nibble_counter #(.CNT_SIZE(3)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .perm_to_count     (perm),
    .width             (width),
    .reverse_direction (rev),
    .is_latest         (is_latest),
    .idx               (idx)
  );

  alu u_alu (
    .args (alu_args),
    .ret  (alu_ret)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;

  logic [31:0] cnt_q[$];
  string       cnt_n[$];
  logic [31:0] alu_q[$];
  string       alu_n[$];
  logic [31:0] word_q[$];
  string       word_n[$];

  logic [31:0] word_res;
  event        alu_ev;
  event        word_ev;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Counter monitor: {is_latest, idx} is observed every falling edge.
  always @(negedge clk) begin
    if (cnt_q.size() > 0) begin
      logic [31:0] e;
      string       n;
      e = cnt_q.pop_front();
      n = cnt_n.pop_front();
      check(n, {28'b0, is_latest, idx}, e);
    end
  end

  // ALU monitor: {carry_out, res}.
  always @(alu_ev) begin
    if (alu_q.size() > 0) begin
      logic [31:0] e;
      string       n;
      e = alu_q.pop_front();
      n = alu_n.pop_front();
      check(n, {27'b0, alu_ret.carry_out, alu_ret.res}, e);
    end
  end

  // Word monitor: assembled 32-bit result of the nibble loop.
  always @(word_ev) begin
    if (word_q.size() > 0) begin
      logic [31:0] e;
      string       n;
      e = word_q.pop_front();
      n = word_n.pop_front();
      check(n, word_res, e);
    end
  end

  // ---------------- driver tasks ----------------
  // Drive inputs for the next rising edge and expect the state after it.
  task automatic cyc(input string nm, input logic p, input logic r, input logic [2:0] w,
                     input logic [2:0] e_idx, input logic e_last);
    perm  = p;
    rev   = r;
    width = w;
    cnt_q.push_back({28'b0, e_last, e_idx});
    cnt_n.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  task automatic alu_vec(input string nm, input AluCmd cmd, input logic cin,
                         input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] e_res, input logic e_cout);
    alu_args.ctrl.cmd           = cmd;
    alu_args.ctrl.ctrl.carry_in = cin;
    alu_args.d1                 = d1;
    alu_args.d2                 = d2;
    alu_q.push_back({27'b0, e_cout, e_res});
    alu_n.push_back(nm);
    #1;
    -> alu_ev;
    #1;
  endtask

  // Full 32-bit word through the loop: one reload clock, then one nibble per
  // clock with carry chained, finishing on the clock that sees is_latest.
  task automatic run_word(input string nm, input AluCmd cmd, input logic r, input logic seed,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    logic [31:0] acc;
    logic        carry;
    logic        done;
    word_q.push_back(exp);
    word_n.push_back(nm);
    width = 3'd7;
    rev   = r;
    perm  = 1'b0;
    @(negedge clk);
    #1;
    perm  = 1'b1;
    carry = seed;
    acc   = '0;
    done  = 1'b0;
    for (int n = 0; n < 12 && !done; n++) begin
      alu_args.ctrl.cmd           = cmd;
      alu_args.ctrl.ctrl.carry_in = carry;
      alu_args.d1                 = a[4*idx +: 4];
      alu_args.d2                 = b[4*idx +: 4];
      #1;
      acc[4*idx +: 4] = alu_ret.res;
      carry           = alu_ret.carry_out;
      done            = is_latest;
      if (!done) begin
        @(negedge clk);
        #1;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: got no is_latest want is_latest within 12 clocks", nm);
    end
    word_res = acc;
    -> word_ev;
    #1;
    perm = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n    = 1'b0;
    perm     = 1'b0;
    width    = 3'd7;
    rev      = 1'b0;
    alu_args = '0;
    word_res = '0;

    // Reset state: idx=0, forward with width=7 -> not latest.
    cnt_q.push_back(32'h0);
    cnt_n.push_back("reset");
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Forward full sweep, then saturation.
    cyc("fwd_reload", 1'b0, 1'b0, 3'd7, 3'd0, 1'b0);
    for (int k = 1; k <= 7; k++)
      cyc($sformatf("fwd_%0d", k), 1'b1, 1'b0, 3'd7, 3'(k), (k == 7));
    cyc("fwd_hold_a", 1'b1, 1'b0, 3'd7, 3'd7, 1'b1);
    cyc("fwd_hold_b", 1'b1, 1'b0, 3'd7, 3'd7, 1'b1);

    // Reverse full sweep, then saturation at 0.
    cyc("rev_reload", 1'b0, 1'b1, 3'd7, 3'd7, 1'b0);
    for (int k = 6; k >= 0; k--)
      cyc($sformatf("rev_%0d", k), 1'b1, 1'b1, 3'd7, 3'(k), (k == 0));
    cyc("rev_hold", 1'b1, 1'b1, 3'd7, 3'd0, 1'b1);

    // Reload mid-sweep, forward.
    cyc("mid_fwd_reload", 1'b0, 1'b0, 3'd7, 3'd0, 1'b0);
    for (int k = 1; k <= 4; k++)
      cyc($sformatf("mid_fwd_%0d", k), 1'b1, 1'b0, 3'd7, 3'(k), 1'b0);
    cyc("mid_fwd_back0", 1'b0, 1'b0, 3'd7, 3'd0, 1'b0);

    // Reload mid-sweep, reverse, width=6.
    cyc("mid_rev_reload", 1'b0, 1'b1, 3'd6, 3'd6, 1'b0);
    cyc("mid_rev_5", 1'b1, 1'b1, 3'd6, 3'd5, 1'b0);
    cyc("mid_rev_4", 1'b1, 1'b1, 3'd6, 3'd4, 1'b0);
    cyc("mid_rev_backw", 1'b0, 1'b1, 3'd6, 3'd6, 1'b0);

    // Partial-width forward sweep.
    cyc("w3_reload", 1'b0, 1'b0, 3'd3, 3'd0, 1'b0);
    cyc("w3_1", 1'b1, 1'b0, 3'd3, 3'd1, 1'b0);
    cyc("w3_2", 1'b1, 1'b0, 3'd3, 3'd2, 1'b0);
    cyc("w3_3", 1'b1, 1'b0, 3'd3, 3'd3, 1'b1);
    cyc("w3_hold", 1'b1, 1'b0, 3'd3, 3'd3, 1'b1);

    // width=0: single-nibble sweep in both directions.
    cyc("w0_fwd_reload", 1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
    cyc("w0_fwd_hold", 1'b1, 1'b0, 3'd0, 3'd0, 1'b1);
    cyc("w0_rev_reload", 1'b0, 1'b1, 3'd0, 3'd0, 1'b1);
    cyc("w0_rev_hold", 1'b1, 1'b1, 3'd0, 3'd0, 1'b1);

    // Async reset mid-sweep: assert between edges, observe before any rising edge.
    cyc("ar_reload", 1'b0, 1'b0, 3'd7, 3'd0, 1'b0);
    cyc("ar_1", 1'b1, 1'b0, 3'd7, 3'd1, 1'b0);
    cyc("ar_2", 1'b1, 1'b0, 3'd7, 3'd2, 1'b0);
    cnt_q.push_back(32'h0);
    cnt_n.push_back("async_reset");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc("ar_after", 1'b0, 1'b0, 3'd7, 3'd0, 1'b0);

    // ALU vectors.
    alu_vec("alu_add_f_1",    ADD,   1'b0, 4'hf, 4'h1, 4'h0, 1'b1);
    alu_vec("alu_add_e_0_c",  ADD,   1'b1, 4'he, 4'h0, 4'hf, 1'b0);
    alu_vec("alu_rsh_6",      RSHFT, 1'b0, 4'h0, 4'h6, 4'h3, 1'b0);
    alu_vec("alu_rsh_1_c",    RSHFT, 1'b1, 4'h9, 4'h1, 4'h8, 1'b1);
    alu_vec("alu_sub_3_5",    SUB,   1'b1, 4'h3, 4'h5, 4'he, 1'b0);
    alu_vec("alu_sub_5_3",    SUB,   1'b1, 4'h5, 4'h3, 4'h2, 1'b1);
    alu_vec("alu_and",        AND,   1'b1, 4'ha, 4'h6, 4'h2, 1'b0);
    alu_vec("alu_or",         OR,    1'b1, 4'h9, 4'h6, 4'hf, 1'b0);
    alu_vec("alu_xor",        XOR,   1'b1, 4'hf, 4'h5, 4'ha, 1'b0);
    alu_vec("alu_undef",      AluCmd'(3'd7), 1'b1, 4'hf, 4'hf, 4'h0, 1'b0);

    // 32-bit loop integration.
    run_word("word_add_carry", ADD,   1'b0, 1'b0, 32'hefffffff, 32'h00000001, 32'hf0000000);
    run_word("word_add_mix",   ADD,   1'b0, 1'b0, 32'hffff0fff, 32'h00000002, 32'hffff1001);
    run_word("word_rshift",    RSHFT, 1'b1, 1'b0, 32'h00000000, 32'h06000000, 32'h03000000);
    run_word("word_sub",       SUB,   1'b0, 1'b1, 32'h00000005, 32'h00000003, 32'h00000002);

    // Drain and report.
    repeat (2) @(negedge clk);
    #1;
    if (cnt_q.size() + alu_q.size() + word_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0 pending",
               cnt_q.size() + alu_q.size() + word_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
